mem_seq_ctrl: RTL and testbench
===============================

// Module: mem_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the RV32I datapath. Shares a single-ported memory between instruction fetch and load/store.
//  Per instruction: fetches into an instruction register, lets the datapath evaluate, optionally runs one data access,
//  then commits. Commit means it pulses the PC enable and gates RegWrite. Sits between the core datapath/control unit and the memory.
// PARAMETERS
//  TIMEOUT   16   cycles mem_ready may stay low in FETCH/DATA before a bus error (>=2)
//  RESET_PC  0    informational only; PC register lives in the datapath
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-high reset
//  pc           in   32  current PC from datapath
//  alu_addr     in   32  load/store effective address (ALU result)
//  store_data   in   32  rs2 data for stores
//  mem_rd       in   1   decoded instruction is a load (valid in EXEC)
//  mem_wr       in   1   decoded instruction is a store (valid in EXEC)
//  ls_size      in   2   00 byte, 01 half, 10 word; 11 = word
//  instr        out  32  instruction register to datapath/control
//  load_data    out  32  registered raw memory word for load extend logic
//  pc_en        out  1   one-cycle PC update strobe
//  reg_wr_en    out  1   AND-gate for RegWrite; high only in WB
//  mem_req      out  1   memory request
//  mem_we       out  1   memory write
//  mem_addr     out  32  memory address, word aligned ([1:0]=00)
//  mem_wdata    out  32  store data lane-replicated
//  mem_wstrb    out  4   byte write strobes
//  mem_rdata    in   32  memory read data, valid when mem_ready
//  mem_ready    in   1   access complete this cycle; may be combinational from mem_req
//  err          out  1   sticky fault flag
//  err_code     out  2   01 timeout, 10 misaligned, 00 none
// BEHAVIOUR
//  - Reset state (async): state=FETCH, instr=32'h00000013 (NOP), load_data=0, timeout counter=0, err=0, err_code=00.
//  - While reset is high, every output is 0 except instr.
//  - States: FETCH -> EXEC -> (DATA if mem_rd|mem_wr) -> WB -> FETCH; any -> ERR on fault; ERR is terminal until reset.
//  - FETCH: mem_req=1, mem_we=0, mem_addr={pc[31:2],2'b00}, mem_wstrb=0.
//    On mem_ready, mem_rdata -> instr and go to EXEC.
//  - EXEC: no memory activity; one cycle for the datapath to settle.
//    mem_rd|mem_wr -> alignment check, then DATA; else -> WB. If mem_rd and mem_wr are both set, treat as a store.
//  - Alignment: half needs alu_addr[0]=0; word needs alu_addr[1:0]=00.
//    On violation: no request issued, go to ERR with err_code=10.
//  - DATA: mem_req=1, mem_we=mem_wr, mem_addr={alu_addr[31:2],2'b00}.
//    Stores:
//      byte: wdata={4{sd[7:0]}},  wstrb=4'b0001<<alu_addr[1:0]
//      half: wdata={2{sd[15:0]}}, wstrb=alu_addr[1]?1100:0011
//      word: wdata=sd,            wstrb=1111
//    Loads: wstrb=0000.
//    On mem_ready, loads capture mem_rdata -> load_data. Go to WB.
//  - WB: pc_en=1 and reg_wr_en=1 for exactly this cycle. Next state FETCH.
//  - mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb are held stable while mem_req=1 and mem_ready=0.
//  - Timeout: counter clears on entry to FETCH/DATA and increments each cycle mem_ready=0.
//    If it reaches TIMEOUT-1 with mem_ready still 0 -> ERR, err_code=01.
//    mem_ready in that same cycle wins over timeout.
//  - ERR: err=1, mem_req=0, pc_en=0, reg_wr_en=0 until reset.
//  - Latency with zero-wait memory: ALU/branch 3 cycles; load/store 4 cycles. Each wait cycle adds 1.
//  - Reset mid-access drops mem_req asynchronously; no partial commit; restarts at FETCH.
// TESTING
//  1. Zero-wait mem, ADDI at pc=0: req@FETCH addr=0; instr latched; pc_en pulses in cycle 3 only; reg_wr_en same cycle.
//  2. SW x=32'hDEADBEEF at addr 0x104: DATA has mem_we=1, addr=0x104, wstrb=1111; WB in cycle 4.
//  3. SB 0xAB at 0x103: wdata=0xABABABAB, wstrb=1000.
//     LH at 0x102 with rdata=0x12345678: load_data=0x12345678.
//  4. mem_ready held low for TIMEOUT=16 in FETCH -> err=1, err_code=01 after 16 req cycles.
//     mem_req then 0 and pc_en never pulses.
//     Ready at cycle 16 instead -> normal EXEC.
//  5. LW at 0x102 -> no DATA request, err_code=10, stuck in ERR.
//     Assert reset -> err=0, FETCH restarts.
//  6. Assert reset during DATA wait: mem_req falls same cycle, no pc_en/reg_wr_en pulse.
//     After release, first request is a fetch.

Source files
------------

// File: rtl/mem_seq_ctrl_if.sv
// Single-ported memory bus shared by instruction fetch and load/store.
// The controller drives the request side; the memory returns data and ready.
interface mem_seq_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_seq_ctrl.sv
// Multi-cycle fetch/exec/data/writeback sequencer for an RV32I core sharing one memory port
// between instruction fetch and load/store, with access timeout and misalignment faults.
module mem_seq_ctrl #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           pc,
    input  logic [31:0]           alu_addr,
    input  logic [31:0]           store_data,
    input  logic                  mem_rd,
    input  logic                  mem_wr,
    input  logic [1:0]            ls_size,
    output logic [31:0]           instr,
    output logic [31:0]           load_data,
    output logic                  pc_en,
    output logic                  reg_wr_en,
    output logic                  err,
    output logic [1:0]            err_code,
    mem_seq_ctrl_if.master        bus
);

    localparam int unsigned    CntW   = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);
    localparam logic [31:0]     Nop    = 32'h0000_0013;

    typedef enum logic [2:0] {StFetch, StExec, StData, StWb, StErr} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [31:0]     instr_q;
    logic [31:0]     load_data_q;
    logic [1:0]      err_code_q;
    logic            store_q;

    logic            misaligned;
    logic [31:0]     st_wdata;
    logic [3:0]      st_wstrb;

    // PC lives in the datapath; the low PC bits are ignored because fetches are word aligned.
    logic unused_bits;
    assign unused_bits = ^{RESET_PC, pc[1:0]};

    always_comb begin
        misaligned = 1'b0;
        st_wdata   = store_data;
        st_wstrb   = 4'b1111;
        case (ls_size)
            2'b00: begin
                st_wdata = {4{store_data[7:0]}};
                st_wstrb = 4'b0001 << alu_addr[1:0];
            end
            2'b01: begin
                misaligned = alu_addr[0];
                st_wdata   = {2{store_data[15:0]}};
                st_wstrb   = alu_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: misaligned = |alu_addr[1:0];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StFetch;
            cnt_q       <= '0;
            instr_q     <= Nop;
            load_data_q <= '0;
            err_code_q  <= 2'b00;
            store_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StFetch: begin
                    // A ready in the final allowed cycle takes priority over the timeout.
                    if (bus.mem_ready) begin
                        instr_q <= bus.mem_rdata;
                        state_q <= StExec;
                    end else if (cnt_q == CntMax) begin
                        state_q    <= StErr;
                        err_code_q <= 2'b01;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StExec: begin
                    if (mem_rd || mem_wr) begin
                        store_q <= mem_wr;
                        if (misaligned) begin
                            state_q    <= StErr;
                            err_code_q <= 2'b10;
                        end else begin
                            state_q <= StData;
                            cnt_q   <= '0;
                        end
                    end else begin
                        state_q <= StWb;
                    end
                end
                StData: begin
                    if (bus.mem_ready) begin
                        if (!store_q) load_data_q <= bus.mem_rdata;
                        state_q <= StWb;
                    end else if (cnt_q == CntMax) begin
                        state_q    <= StErr;
                        err_code_q <= 2'b01;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StWb: begin
                    state_q <= StFetch;
                    cnt_q   <= '0;
                end
                StErr: state_q <= StErr;
                default: state_q <= StErr;
            endcase
        end
    end

    // Outputs decode the state directly and are forced low while reset is held, so an
    // in-flight request is dropped the moment reset rises.
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = 4'b0000;
        pc_en         = 1'b0;
        reg_wr_en     = 1'b0;
        err           = 1'b0;
        err_code      = 2'b00;
        if (!reset) begin
            err_code = err_code_q;
            unique case (state_q)
                StFetch: begin
                    bus.mem_req  = 1'b1;
                    bus.mem_addr = {pc[31:2], 2'b00};
                end
                StData: begin
                    bus.mem_req  = 1'b1;
                    bus.mem_we   = store_q;
                    bus.mem_addr = {alu_addr[31:2], 2'b00};
                    if (store_q) begin
                        bus.mem_wdata = st_wdata;
                        bus.mem_wstrb = st_wstrb;
                    end
                end
                StWb: begin
                    pc_en     = 1'b1;
                    reg_wr_en = 1'b1;
                end
                StErr:   err = 1'b1;
                default: ;
            endcase
        end
    end

    assign instr     = instr_q;
    assign load_data = load_data_q;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Scoreboard bench for mem_seq_ctrl: stimulus pushes expected bus accesses and commits,
// a negedge monitor pops and compares them as the DUT completes accesses and pulses pc_en.
module tb_mem_seq_ctrl;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } acc_t;

    typedef struct packed {
        logic [31:0] lat;
        logic [31:0] iw;
        logic        chk_ld;
        logic [31:0] ld;
    } com_t;

    localparam logic [31:0] Nop  = 32'h0000_0013;
    localparam logic [31:0] Addi = 32'h0050_0093;
    localparam logic [31:0] Ldw  = 32'h0000_2083;
    localparam logic [31:0] Stw  = 32'h0010_2023;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc = '0, alu_addr = '0, store_data = '0;
    logic        mem_rd = 1'b0, mem_wr = 1'b0;
    logic [1:0]  ls_size = 2'b00;
    logic [31:0] instr, load_data;
    logic        pc_en, reg_wr_en, err;
    logic [1:0]  err_code;

    logic [31:0] fetch_word = Nop, load_word = '0;
    int          stall_need = 0, stall_cnt = 0;
    int          cyc = 0, instr_start = 0;
    int          n_cmp = 0, n_bad = 0;
    acc_t        acc_q[$];
    com_t        commit_q[$];
    acc_t        mon_a;
    com_t        mon_c;

    mem_seq_ctrl_if bus ();

    mem_seq_ctrl #(.TIMEOUT(16), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .pc(pc), .alu_addr(alu_addr), .store_data(store_data),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .ls_size(ls_size), .instr(instr),
        .load_data(load_data), .pc_en(pc_en), .reg_wr_en(reg_wr_en), .err(err),
        .err_code(err_code), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) stall_cnt <= (bus.mem_req && !bus.mem_ready) ? stall_cnt + 1 : 0;

    assign bus.mem_ready = bus.mem_req && (stall_cnt >= stall_need);
    assign bus.mem_rdata = (bus.mem_addr == {pc[31:2], 2'b00}) ? fetch_word : load_word;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_req && bus.mem_ready) begin
                if (acc_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_access: got addr %h we %b, expected none",
                             bus.mem_addr, bus.mem_we);
                end else begin
                    mon_a = acc_q.pop_front();
                    check("acc_addr", bus.mem_addr, mon_a.addr);
                    check("acc_we", {31'b0, bus.mem_we}, {31'b0, mon_a.we});
                    check("acc_wstrb", {28'b0, bus.mem_wstrb}, {28'b0, mon_a.wstrb});
                    if (mon_a.we) check("acc_wdata", bus.mem_wdata, mon_a.wdata);
                end
            end
            if (pc_en || reg_wr_en) begin
                check("reg_wr_en_with_pc_en", {31'b0, reg_wr_en}, {31'b0, pc_en});
                if (commit_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_commit: got pc_en=1, expected none (t=%0t)", $time);
                end else begin
                    mon_c = commit_q.pop_front();
                    check("commit_latency", 32'(cyc - instr_start + 1), mon_c.lat);
                    check("commit_instr", instr, mon_c.iw);
                    if (mon_c.chk_ld) check("commit_load_data", load_data, mon_c.ld);
                end
                instr_start = cyc + 1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        instr_start = cyc;
    endtask

    task automatic set_in(input logic [31:0] p, input logic [31:0] iw, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] lw, input logic rd,
                          input logic wr, input logic [1:0] sz, input int stall);
        pc = p; fetch_word = iw; alu_addr = a; store_data = sd; load_word = lw;
        mem_rd = rd; mem_wr = wr; ls_size = sz; stall_need = stall;
    endtask

    task automatic exp_acc(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] st);
        acc_q.push_back('{we: we, addr: addr, wdata: wd, wstrb: st});
    endtask

    task automatic exp_commit(input int lat, input logic [31:0] iw, input logic chk,
                              input logic [31:0] ld);
        commit_q.push_back('{lat: 32'(lat), iw: iw, chk_ld: chk, ld: ld});
    endtask

    task automatic wait_commits(input string name);
        for (int i = 0; i < 60 && commit_q.size() != 0; i++) tick();
        check({name, "_commits_done"}, 32'(commit_q.size()), 32'd0);
        check({name, "_accesses_done"}, 32'(acc_q.size()), 32'd0);
        commit_q.delete();
        acc_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_instr"}, instr, Nop);
        check({name, "_load_data"}, load_data, 32'd0);
        check({name, "_mem_req"}, {31'b0, bus.mem_req}, 32'd0);
        check({name, "_mem_we"}, {31'b0, bus.mem_we}, 32'd0);
        check({name, "_mem_addr"}, bus.mem_addr, 32'd0);
        check({name, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        check({name, "_mem_wstrb"}, {28'b0, bus.mem_wstrb}, 32'd0);
        check({name, "_pc_en"}, {31'b0, pc_en}, 32'd0);
        check({name, "_reg_wr_en"}, {31'b0, reg_wr_en}, 32'd0);
        check({name, "_err"}, {31'b0, err}, 32'd0);
        check({name, "_err_code"}, {30'b0, err_code}, 32'd0);
    endtask

    initial begin
        int nreq;
        #2 reset = 1'b1;
        tick(); tick();
        check_reset_outputs("reset");

        // Zero-wait ALU, stores, loads, wait states.
        set_in(32'h0, Addi, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b10, 0);
        exp_acc(1'b0, 32'h0, 32'h0, 4'b0000);
        exp_commit(3, Addi, 1'b0, 32'h0);
        release_reset();
        wait_commits("addi");

        set_in(32'h4, Stw, 32'h104, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 2'b10, 0);
        exp_acc(1'b0, 32'h4, 32'h0, 4'b0000);
        exp_acc(1'b1, 32'h104, 32'hDEADBEEF, 4'b1111);
        exp_commit(4, Stw, 1'b0, 32'h0);
        wait_commits("sw");

        set_in(32'h8, Stw, 32'h103, 32'h123456AB, 32'h0, 1'b0, 1'b1, 2'b00, 0);
        exp_acc(1'b0, 32'h8, 32'h0, 4'b0000);
        exp_acc(1'b1, 32'h100, 32'hABABABAB, 4'b1000);
        exp_commit(4, Stw, 1'b0, 32'h0);
        wait_commits("sb");

        set_in(32'hC, Ldw, 32'h102, 32'h0, 32'h12345678, 1'b1, 1'b0, 2'b01, 0);
        exp_acc(1'b0, 32'hC, 32'h0, 4'b0000);
        exp_acc(1'b0, 32'h100, 32'h0, 4'b0000);
        exp_commit(4, Ldw, 1'b1, 32'h12345678);
        wait_commits("lh");

        set_in(32'h10, Stw, 32'h106, 32'hCAFEBEEF, 32'h0, 1'b0, 1'b1, 2'b01, 0);
        exp_acc(1'b0, 32'h10, 32'h0, 4'b0000);
        exp_acc(1'b1, 32'h104, 32'hBEEFBEEF, 4'b1100);
        exp_commit(4, Stw, 1'b0, 32'h0);
        wait_commits("sh");

        set_in(32'h14, Ldw, 32'h101, 32'h0, 32'hA5A51234, 1'b1, 1'b0, 2'b00, 2);
        exp_acc(1'b0, 32'h14, 32'h0, 4'b0000);
        exp_acc(1'b0, 32'h100, 32'h0, 4'b0000);
        exp_commit(8, Ldw, 1'b1, 32'hA5A51234);
        wait_commits("lb_wait2");

        set_in(32'h18, Stw, 32'h108, 32'h0BADF00D, 32'h0, 1'b1, 1'b1, 2'b11, 0);
        exp_acc(1'b0, 32'h18, 32'h0, 4'b0000);
        exp_acc(1'b1, 32'h108, 32'h0BADF00D, 4'b1111);
        exp_commit(4, Stw, 1'b0, 32'h0);
        wait_commits("rdwr_store");

        set_in(32'h1C, Addi, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b10, 1);
        exp_acc(1'b0, 32'h1C, 32'h0, 4'b0000);
        exp_commit(4, Addi, 1'b0, 32'h0);
        wait_commits("addi_wait1");

        // Fetch timeout: ready never arrives.
        reset = 1'b1;
        tick();
        set_in(32'h40, Addi, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b10, 1000);
        release_reset();
        nreq = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.mem_req) nreq++;
            if (err) break;
        end
        check("timeout_req_cycles", 32'(nreq), 32'd16);
        check("timeout_err", {31'b0, err}, 32'd1);
        check("timeout_err_code", {30'b0, err_code}, 32'd1);
        for (int i = 0; i < 5; i++) tick();
        check("timeout_req_dropped", {31'b0, bus.mem_req}, 32'd0);
        check("timeout_err_sticky", {31'b0, err}, 32'd1);

        // Ready in the last allowed cycle completes the fetch normally.
        reset = 1'b1;
        tick();
        check("reset_clears_err", {31'b0, err}, 32'd0);
        set_in(32'h44, Addi, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b10, 15);
        exp_acc(1'b0, 32'h44, 32'h0, 4'b0000);
        exp_commit(18, Addi, 1'b0, 32'h0);
        release_reset();
        wait_commits("ready_at_16");

        // Misaligned word load faults without a data request.
        reset = 1'b1;
        tick();
        set_in(32'h20, Ldw, 32'h102, 32'h0, 32'h0, 1'b1, 1'b0, 2'b10, 0);
        exp_acc(1'b0, 32'h20, 32'h0, 4'b0000);
        release_reset();
        for (int i = 0; i < 10 && !err; i++) tick();
        check("misalign_err", {31'b0, err}, 32'd1);
        check("misalign_err_code", {30'b0, err_code}, 32'd2);
        for (int i = 0; i < 3; i++) tick();
        check("misalign_no_req", {31'b0, bus.mem_req}, 32'd0);
        check("misalign_fetch_seen", 32'(acc_q.size()), 32'd0);
        reset = 1'b1;
        #1;
        check_reset_outputs("reset_after_err");
        tick();
        set_in(32'h24, Addi, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b10, 0);
        exp_acc(1'b0, 32'h24, 32'h0, 4'b0000);
        exp_commit(3, Addi, 1'b0, 32'h0);
        release_reset();
        wait_commits("restart_after_err");

        // Reset during a stalled data access.
        reset = 1'b1;
        tick();
        set_in(32'h30, Ldw, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0, 2'b10, 5);
        exp_acc(1'b0, 32'h30, 32'h0, 4'b0000);
        release_reset();
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.mem_req && bus.mem_addr == 32'h100) break;
        end
        check("data_wait_addr", bus.mem_addr, 32'h100);
        reset = 1'b1;
        #1;
        check("midreset_req", {31'b0, bus.mem_req}, 32'd0);
        check("midreset_pc_en", {31'b0, pc_en}, 32'd0);
        check("midreset_reg_wr_en", {31'b0, reg_wr_en}, 32'd0);
        tick(); tick();
        set_in(32'h34, Addi, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b10, 0);
        exp_acc(1'b0, 32'h34, 32'h0, 4'b0000);
        exp_commit(3, Addi, 1'b0, 32'h0);
        release_reset();
        wait_commits("fetch_after_midreset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
